mem_ram_pipelined: RTL

- Parametrised single-port data/instruction RAM for the core.
- Next generation of the simulated 64 KB RAM: configurable width, depth and read latency.
- Adds a valid/ready request handshake, byte addressing with range checking, and a deterministic post-reset clear sequence.
- Exactly one response per accepted request; sits between the load/store unit and the memory map.

---
 rtl/mem_ram_pipelined_pkg.sv | 11 +
 rtl/mem_ram_pipelined_rsp_pipe.sv | 56 +++++
 rtl/mem_ram_pipelined.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_ram_pipelined_pkg.sv
// Shared types and limits for the pipelined RAM and its response delay line.
package mem_ram_pipelined_pkg;

  localparam int MEM_MAX_READ_LATENCY = 4;

  typedef enum logic [0:0] {
    MEM_ST_CLEAR = 1'b0,
    MEM_ST_READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_ram_pipelined_rsp_pipe.sv
// Delay line for RAM responses (valid, error, data); each stage loads only
// when its input is valid so the output data holds between responses.
module mem_ram_pipelined_rsp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vld_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign vld_o  = vld_i;
    assign err_o  = err_i;
    assign data_o = data_i;
  end else begin : g_stages
    logic                  vld_q  [STAGES];
    logic                  err_q  [STAGES];
    logic [DATA_WIDTH-1:0] data_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < STAGES; i++) begin
          vld_q[i]  <= 1'b0;
          err_q[i]  <= 1'b0;
          data_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= vld_i;
        if (vld_i) begin
          err_q[0]  <= err_i;
          data_q[0] <= data_i;
        end
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            err_q[i]  <= err_q[i-1];
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

    assign vld_o  = vld_q[STAGES-1];
    assign err_o  = err_q[STAGES-1];
    assign data_o = data_q[STAGES-1];
  end

endmodule

// File: rtl/mem_ram_pipelined.sv
// Single-port byte-maskable RAM with valid/ready requests, range checking,
// post-reset clear sequence and configurable read latency.
module mem_ram_pipelined
  import mem_ram_pipelined_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 16384,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   address_i,
  input  logic [DATA_WIDTH/8-1:0] wr_mask_i,
  input  logic [DATA_WIDTH-1:0]   data_in_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   data_out_o,
  output logic                    rsp_err_o,
  output logic                    init_done_o
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFF_W       = $clog2(BYTES);
  localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT         = (READ_LATENCY > MEM_MAX_READ_LATENCY) ? MEM_MAX_READ_LATENCY :
                               (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam int PIPE_STAGES = LAT - 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  mem_state_e       state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? MEM_ST_CLEAR : MEM_ST_READY;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // ready/done are registered copies of the next state so they rise together
  // with the first READY cycle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      MEM_ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = MEM_ST_READY;
      end
      default: state_d = MEM_ST_READY;
    endcase
    ready_d = (state_d == MEM_ST_READY);
    done_d  = (state_d == MEM_ST_READY);
  end

  assign req_ready_o = ready_q;
  assign init_done_o = done_q;

  // Request decode: high address bits only matter for the range check.
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      idx;
  logic                  in_range, accept, is_wr, wr_en, clear_we;

  assign word_addr = address_i >> OFF_W;
  assign in_range  = (word_addr < ADDR_WIDTH'(DEPTH));
  assign idx       = word_addr[IDX_W-1:0];
  assign accept    = req_valid_i & ready_q;
  assign is_wr     = |wr_mask_i;
  assign wr_en     = accept & is_wr & in_range;
  assign clear_we  = (state_q == MEM_ST_CLEAR);

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_mask_i[b]) mem_q[idx][b*8 +: 8] <= data_in_i[b*8 +: 8];
      end
    end
  end

  // Stage p0: array sampled at the accept edge
  logic                  vld_p0_q, err_p0_q;
  logic [DATA_WIDTH-1:0] data_p0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0_q  <= 1'b0;
      err_p0_q  <= 1'b0;
      data_p0_q <= '0;
    end else begin
      vld_p0_q <= accept;
      if (accept) begin
        err_p0_q  <= ~in_range;
        data_p0_q <= (!is_wr && in_range) ? mem_q[idx] : '0;
      end
    end
  end

  // Stages p1..: extra latency beyond the array read
  mem_ram_pipelined_rsp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .STAGES    (PIPE_STAGES)
  ) u_rsp_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .vld_i  (vld_p0_q),
    .err_i  (err_p0_q),
    .data_i (data_p0_q),
    .vld_o  (rsp_valid_o),
    .err_o  (rsp_err_o),
    .data_o (data_out_o)
  );

endmodule
